// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: RV32 opcode constants,
// FSM state encoding, operation field layout and the illegal-operation decode.
package alu_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 17;

    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] STYPE  = 7'b0100011;
    localparam logic [6:0] BTYPE  = 7'b1100011;
    localparam logic [6:0] UJTYPE = 7'b1101111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic [6:0] opcode;
    } op_t;

    // Stores have no ALU result; ADD/SUB and shift-right only accept the base or alternate funct7.
    function automatic logic isIllegalOp(input logic [OPW-1:0] op);
        op_t f;
        f = op;
        if (f.opcode == STYPE) begin
            return 1'b1;
        end
        if ((f.opcode == RTYPE) &&
            ((f.funct3 == 3'b000) || (f.funct3 == 3'b101)) &&
            !((f.funct7 == FUNCT7_BASE) || (f.funct7 == FUNCT7_ALT))) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational RV32 integer ALU: register/immediate arithmetic, shifts,
// compares, branch-condition evaluation and jump-target addition.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [OPW-1:0]  i_op,
    output logic [XLEN-1:0] o_y
);

    op_t                    w_op;
    logic [4:0]             w_shamt;
    logic                   w_alt;
    logic signed [XLEN-1:0] w_sra;
    logic                   w_lt;
    logic                   w_ltu;

    assign w_op    = i_op;
    assign w_shamt = i_b[4:0];
    assign w_alt   = (w_op.funct7 == FUNCT7_ALT);
    // Kept in its own signed net so the arithmetic shift is not demoted to a logical one.
    assign w_sra   = $signed(i_a) >>> w_shamt;
    assign w_lt    = ($signed(i_a) < $signed(i_b));
    assign w_ltu   = (i_a < i_b);

    always_comb begin
        o_y = '0;
        case (w_op.opcode)
            RTYPE, ITYPE: begin
                case (w_op.funct3)
                    3'b000:  o_y = ((w_op.opcode == RTYPE) && w_alt) ? (i_a - i_b) : (i_a + i_b);
                    3'b001:  o_y = i_a << w_shamt;
                    3'b010:  o_y = {{(XLEN-1){1'b0}}, w_lt};
                    3'b011:  o_y = {{(XLEN-1){1'b0}}, w_ltu};
                    3'b100:  o_y = i_a ^ i_b;
                    3'b101:  o_y = w_alt ? w_sra : (i_a >> w_shamt);
                    3'b110:  o_y = i_a | i_b;
                    default: o_y = i_a & i_b;
                endcase
            end
            BTYPE: begin
                case (w_op.funct3)
                    3'b000:  o_y = {{(XLEN-1){1'b0}}, (i_a == i_b)};
                    3'b001:  o_y = {{(XLEN-1){1'b0}}, (i_a != i_b)};
                    3'b100:  o_y = {{(XLEN-1){1'b0}}, w_lt};
                    3'b101:  o_y = {{(XLEN-1){1'b0}}, !w_lt};
                    3'b110:  o_y = {{(XLEN-1){1'b0}}, w_ltu};
                    3'b111:  o_y = {{(XLEN-1){1'b0}}, !w_ltu};
                    default: o_y = '0;
                endcase
            end
            UJTYPE:  o_y = i_a + i_b;
            default: o_y = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU: accepts one
// operation at a time, computes it in two cycles and holds the result until consumed.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [XLEN-1:0]   req0_a,
    input  logic [XLEN-1:0]   req0_b,
    input  logic [OPW-1:0]    req0_op,
    input  logic [XLEN-1:0]   req1_a,
    input  logic [XLEN-1:0]   req1_b,
    input  logic [OPW-1:0]    req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN-1:0]   rsp_y,
    output logic              rsp_err,
    output logic              busy
);

    state_t          r_state;
    state_t          w_nextState;
    logic            r_lastGrant;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [OPW-1:0]  r_op;
    logic            r_id;
    logic [XLEN-1:0] r_y;
    logic            r_err;
    logic            r_rspId;

    logic            w_canAccept;
    logic            w_anyValid;
    logic            w_grantId;
    logic            w_accept;
    logic [XLEN-1:0] w_aluY;
    logic            w_illegal;

    // A new operation may enter only when nothing is held or the held result leaves this cycle.
    always_comb begin
        w_canAccept = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
        w_anyValid  = 1'b0;
        w_grantId   = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            w_anyValid = 1'b1;
            w_grantId  = ~r_lastGrant;
        end else if (req_valid[0]) begin
            w_anyValid = 1'b1;
            w_grantId  = 1'b0;
        end else if (req_valid[1]) begin
            w_anyValid = 1'b1;
            w_grantId  = 1'b1;
        end
        w_accept  = w_anyValid && w_canAccept && rst_n;
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grantId] = 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = ST_EXEC;
            ST_EXEC: w_nextState = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_nextState = w_accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= 1'b0;
        end else if (w_accept) begin
            r_lastGrant <= w_grantId;
            r_a         <= w_grantId ? req1_a  : req0_a;
            r_b         <= w_grantId ? req1_b  : req0_b;
            r_op        <= w_grantId ? req1_op : req0_op;
            r_id        <= w_grantId;
        end
    end

    alu_arbiter_alu u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_y  (w_aluY)
    );

    assign w_illegal = isIllegalOp(r_op);

    // The response registers only load in EXEC, so they stay frozen for the whole RESP stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_err   <= 1'b0;
            r_rspId <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_y     <= w_illegal ? '0 : w_aluY;
            r_err   <= w_illegal;
            r_rspId <= r_id;
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_y     = r_y;
    assign rsp_err   = r_err;
    assign rsp_id    = r_rspId;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: each task drives one scenario and checks
// handshakes, latency and results against hand-computed values.
module tb_alu_arbiter;

    localparam logic [16:0] OP_ADD   = {7'b0000000, 3'b000, 7'b0110011};
    localparam logic [16:0] OP_SUB   = {7'b0100000, 3'b000, 7'b0110011};
    localparam logic [16:0] OP_XOR   = {7'b0000000, 3'b100, 7'b0110011};
    localparam logic [16:0] OP_SRA   = {7'b0100000, 3'b101, 7'b0110011};
    localparam logic [16:0] OP_SRL   = {7'b0000000, 3'b101, 7'b0110011};
    localparam logic [16:0] OP_BAD   = {7'b0000001, 3'b000, 7'b0110011};
    localparam logic [16:0] OP_STORE = {7'b0000000, 3'b010, 7'b0100011};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [16:0] req0_op, req1_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_y;
    logic        rsp_err;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // Called at a negedge with the DUT idle; returns at the negedge where the result is presented.
    task automatic issueOp(input int id, input logic [31:0] a, input logic [31:0] b, input logic [16:0] op);
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req_valid = 2'b01;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req_valid = 2'b10;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic finishOp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = OP_ADD;
        req1_a = '0; req1_b = '0; req1_op = OP_ADD;
        #7;
        compared++; if (req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 00", req_ready); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", rsp_valid); end
        compared++; if ({rsp_id, rsp_err, rsp_y} !== 34'd0) begin mismatched++; $display("[TB] FAIL reset_rsp: got id=%b err=%b y=%h expected all 0", rsp_id, rsp_err, rsp_y); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;
    endtask

    task automatic test_tie();
        req0_a = 32'd10;  req0_b = 32'd3;  req0_op = OP_SUB;
        req1_a = 32'hF0;  req1_b = 32'h0F; req1_op = OP_XOR;
        rsp_ready = 1'b1; req_valid = 2'b11;
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL tie_grant0: got %b expected 01", req_ready); end
        @(negedge clk);
        compared++; if (req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL tie_exec_ready: got %b expected 00", req_ready); end
        @(negedge clk);
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL tie_grant1: got %b expected 10", req_ready); end
        compared++; if ({rsp_valid, rsp_id, rsp_err, rsp_y} !== {1'b1, 1'b0, 1'b0, 32'd7}) begin mismatched++; $display("[TB] FAIL tie_rsp0: got v=%b id=%b err=%b y=%h expected v=1 id=0 err=0 y=7", rsp_valid, rsp_id, rsp_err, rsp_y); end
        @(negedge clk);
        @(negedge clk);
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL tie_grant2: got %b expected 01", req_ready); end
        compared++; if ({rsp_valid, rsp_id, rsp_err, rsp_y} !== {1'b1, 1'b1, 1'b0, 32'hFF}) begin mismatched++; $display("[TB] FAIL tie_rsp1: got v=%b id=%b err=%b y=%h expected v=1 id=1 err=0 y=ff", rsp_valid, rsp_id, rsp_err, rsp_y); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        compared++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 32'd7}) begin mismatched++; $display("[TB] FAIL tie_rsp2: got v=%b id=%b y=%h expected v=1 id=0 y=7", rsp_valid, rsp_id, rsp_y); end
        finishOp();
    endtask

    task automatic test_single_add();
        req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD;
        rsp_ready = 1'b1; req_valid = 2'b01;
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL add_accept: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        compared++; if ({rsp_valid, busy} !== 2'b01) begin mismatched++; $display("[TB] FAIL add_t1: got v=%b busy=%b expected v=0 busy=1", rsp_valid, busy); end
        @(negedge clk);
        compared++; if ({rsp_valid, rsp_id, rsp_err, rsp_y} !== {1'b1, 1'b0, 1'b0, 32'd12}) begin mismatched++; $display("[TB] FAIL add_rsp: got v=%b id=%b err=%b y=%h expected v=1 id=0 err=0 y=c", rsp_valid, rsp_id, rsp_err, rsp_y); end
        finishOp();
        compared++; if ({rsp_valid, busy} !== 2'b00) begin mismatched++; $display("[TB] FAIL add_idle: got v=%b busy=%b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_backpressure();
        req1_a = 32'd100; req1_b = 32'd23; req1_op = OP_ADD;
        rsp_ready = 1'b0; req_valid = 2'b10;
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL bp_accept: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD; req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            compared++; if ({rsp_valid, rsp_id, rsp_err, rsp_y, req_ready} !== {1'b1, 1'b1, 1'b0, 32'd123, 2'b00}) begin mismatched++; $display("[TB] FAIL bp_hold%0d: got v=%b id=%b err=%b y=%h rdy=%b expected v=1 id=1 err=0 y=7b rdy=00", i, rsp_valid, rsp_id, rsp_err, rsp_y, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL bp_release_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        compared++; if ({rsp_valid, busy} !== 2'b01) begin mismatched++; $display("[TB] FAIL bp_single: got v=%b busy=%b expected v=0 busy=1", rsp_valid, busy); end
        @(negedge clk);
        compared++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 32'd2}) begin mismatched++; $display("[TB] FAIL bp_next: got v=%b id=%b y=%h expected v=1 id=0 y=2", rsp_valid, rsp_id, rsp_y); end
        finishOp();
    endtask

    task automatic test_illegal();
        rsp_ready = 1'b1;
        issueOp(0, 32'd3, 32'd4, OP_BAD);
        compared++; if ({rsp_valid, rsp_err, rsp_y} !== {1'b1, 1'b1, 32'd0}) begin mismatched++; $display("[TB] FAIL illegal_funct7: got v=%b err=%b y=%h expected v=1 err=1 y=0", rsp_valid, rsp_err, rsp_y); end
        finishOp();
        issueOp(1, 32'd3, 32'd4, OP_STORE);
        compared++; if ({rsp_valid, rsp_id, rsp_err, rsp_y} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin mismatched++; $display("[TB] FAIL illegal_store: got v=%b id=%b err=%b y=%h expected v=1 id=1 err=1 y=0", rsp_valid, rsp_id, rsp_err, rsp_y); end
        finishOp();
    endtask

    task automatic test_sra();
        rsp_ready = 1'b1;
        issueOp(0, 32'h8000_0000, 32'd4, OP_SRA);
        compared++; if ({rsp_err, rsp_y} !== {1'b0, 32'hF800_0000}) begin mismatched++; $display("[TB] FAIL sra: got err=%b y=%h expected err=0 y=f8000000", rsp_err, rsp_y); end
        finishOp();
        issueOp(0, 32'h8000_0000, 32'd4, OP_SRL);
        compared++; if ({rsp_err, rsp_y} !== {1'b0, 32'h0800_0000}) begin mismatched++; $display("[TB] FAIL srl: got err=%b y=%h expected err=0 y=08000000", rsp_err, rsp_y); end
        finishOp();
    endtask

    task automatic test_reset_exec();
        req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD;
        rsp_ready = 1'b1; req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if ({busy, rsp_valid, req_ready} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_exec_now: got busy=%b v=%b rdy=%b expected 0 0 00", busy, rsp_valid, req_ready); end
        compared++; if (rsp_y !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_exec_y: got %h expected 0", rsp_y); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++; if ({busy, rsp_valid} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_exec_quiet%0d: got busy=%b v=%b expected 0 0", i, busy, rsp_valid); end
        end
        req1_a = 32'hF0; req1_b = 32'h0F; req1_op = OP_XOR;
        req_valid = 2'b11;
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL rst_exec_tie: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        compared++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 32'd12}) begin mismatched++; $display("[TB] FAIL rst_exec_after: got v=%b id=%b y=%h expected v=1 id=0 y=c", rsp_valid, rsp_id, rsp_y); end
        finishOp();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_add();
        test_backpressure();
        test_illegal();
        test_sra();
        test_reset_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
